// File: rtl/scpu_trap_ctrl.sv
// Machine-mode trap and CSR controller for the single-cycle RISC-V CPU.
// Tracks exceptions, the external interrupt, and mret; owns mstatus, mie,
// mtvec, mepc, mcause and mip; and drives the PC redirect into fetch.
module scpu_trap_ctrl #(
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid,
    input  logic        ill_instr,
    input  logic        ecall,
    input  logic        mret,
    input  logic [31:0] pc_cur,
    input  logic [31:0] pc_next,
    input  logic        int_req,
    output logic        int_ack,
    input  logic        csr_we,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        in_handler,
    output logic        halt
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_HANDLER,
        ST_HALT
    } state_e;

    state_e      state_q, state_d;
    logic        sync1_q, irq_s_q;
    logic        mie_q, mie_d;
    logic        mpie_q, mpie_d;
    logic        meie_q, meie_d;
    logic [29:0] mtvec_q, mtvec_d;
    logic [29:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;

    logic exc_any, exc_trap, mret_ev, irq_take, csr_wr;

    // Only the word-aligned parts of the PCs are stored.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc_cur[1:0], pc_next[1:0]};

    // Event qualification and priority: ill/ecall > mret > interrupt > CSR write.
    always_comb begin
        exc_any  = inst_valid & (ill_instr | ecall);
        exc_trap = exc_any & (state_q == ST_RUN);
        mret_ev  = inst_valid & mret & ~ill_instr & ~ecall & (state_q != ST_HALT);
        irq_take = irq_s_q & mie_q & meie_q & inst_valid & (state_q == ST_RUN)
                 & ~ill_instr & ~ecall & ~mret;
        csr_wr   = inst_valid & csr_we & (state_q != ST_HALT)
                 & ~exc_any & ~mret_ev & ~irq_take;
    end

    // Next-state computation for the FSM and every trap CSR.
    always_comb begin
        state_d  = state_q;
        mie_d    = mie_q;
        mpie_d   = mpie_q;
        meie_d   = meie_q;
        mtvec_d  = mtvec_q;
        mepc_d   = mepc_q;
        mcause_d = mcause_q;
        if (exc_any) begin
            // A second exception inside the handler is a double fault.
            if (exc_trap) begin
                mepc_d   = pc_cur[31:2];
                mcause_d = ill_instr ? 32'd2 : 32'd11;
                mpie_d   = mie_q;
                mie_d    = 1'b0;
                state_d  = ST_HANDLER;
            end else if (state_q == ST_HANDLER) begin
                state_d  = ST_HALT;
            end
        end else if (mret_ev) begin
            mie_d   = mpie_q;
            mpie_d  = 1'b1;
            state_d = ST_RUN;
        end else if (irq_take) begin
            mepc_d   = pc_next[31:2];
            mcause_d = 32'h8000_000B;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
            state_d  = ST_HANDLER;
        end else if (csr_wr) begin
            case (csr_addr)
                12'h300: begin
                    mie_d  = csr_wdata[3];
                    mpie_d = csr_wdata[7];
                end
                12'h304: meie_d   = csr_wdata[11];
                12'h305: mtvec_d  = csr_wdata[31:2];
                12'h341: mepc_d   = csr_wdata[31:2];
                12'h342: mcause_d = csr_wdata;
                default: ;
            endcase
        end
    end

    // Two-flop synchronizer for the asynchronous interrupt level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            irq_s_q <= 1'b0;
        end else begin
            sync1_q <= int_req;
            irq_s_q <= sync1_q;
        end
    end

    // FSM and CSR state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_RUN;
            mie_q    <= 1'b0;
            mpie_q   <= 1'b0;
            meie_q   <= 1'b0;
            mtvec_q  <= MTVEC_RST[31:2];
            mepc_q   <= '0;
            mcause_q <= '0;
        end else begin
            state_q  <= state_d;
            mie_q    <= mie_d;
            mpie_q   <= mpie_d;
            meie_q   <= meie_d;
            mtvec_q  <= mtvec_d;
            mepc_q   <= mepc_d;
            mcause_q <= mcause_d;
        end
    end

    // Combinational CSR read port; unmapped addresses read zero.
    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            12'h300: csr_rdata = {24'b0, mpie_q, 3'b0, mie_q, 3'b0};
            12'h304: csr_rdata = {20'b0, meie_q, 11'b0};
            12'h305: csr_rdata = {mtvec_q, 2'b00};
            12'h341: csr_rdata = {mepc_q, 2'b00};
            12'h342: csr_rdata = mcause_q;
            12'h344: csr_rdata = {20'b0, irq_s_q, 11'b0};
            default: csr_rdata = '0;
        endcase
    end

    assign redirect    = exc_trap | mret_ev | irq_take;
    assign redirect_pc = mret_ev ? {mepc_q, 2'b00} : {mtvec_q, 2'b00};
    assign int_ack     = irq_take;
    assign in_handler  = (state_q == ST_HANDLER);
    assign halt        = (state_q == ST_HALT);

endmodule

// File: tb/tb_scpu_trap_ctrl.sv
// Directed self-checking bench for scpu_trap_ctrl with mtvec reset at 0x100.
module tb_scpu_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid, ill_instr, ecall, mret;
    logic [31:0] pc_cur, pc_next;
    logic        int_req, int_ack;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata, csr_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        in_handler, halt;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    scpu_trap_ctrl #(.MTVEC_RST(32'h0000_0100)) dut (
        .clk        (clk),
        .rst        (rst),
        .inst_valid (inst_valid),
        .ill_instr  (ill_instr),
        .ecall      (ecall),
        .mret       (mret),
        .pc_cur     (pc_cur),
        .pc_next    (pc_next),
        .int_req    (int_req),
        .int_ack    (int_ack),
        .csr_we     (csr_we),
        .csr_addr   (csr_addr),
        .csr_wdata  (csr_wdata),
        .csr_rdata  (csr_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .in_handler (in_handler),
        .halt       (halt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic clr();
        inst_valid = 1'b0;
        ill_instr  = 1'b0;
        ecall      = 1'b0;
        mret       = 1'b0;
        csr_we     = 1'b0;
        csr_wdata  = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
        csr_addr = a;
        #1;
        chk(tag, csr_rdata, exp);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        clr();
        inst_valid = 1'b1;
        csr_we     = 1'b1;
        csr_addr   = a;
        csr_wdata  = d;
        step();
        clr();
    endtask

    initial begin
        clr();
        rst = 1'b1; int_req = 1'b0; pc_cur = '0; pc_next = '0; csr_addr = '0;
        step(); step();
        #2 rst = 1'b0;
        step();

        // Reset state
        rd("rst_mtvec", 12'h305, 32'h100);
        rd("rst_mstatus", 12'h300, 32'h0);
        rd("rst_mcause", 12'h342, 32'h0);
        chk("rst_halt", halt, 0);
        chk("rst_redirect", redirect, 0);
        chk("rst_in_handler", in_handler, 0);
        chk("rst_int_ack", int_ack, 0);
        rd("unmapped", 12'h7C0, 32'h0);

        // Events ignored while inst_valid is low
        ecall = 1'b1;
        #1 chk("noval_redirect", redirect, 0);
        step(); clr();
        chk("noval_in_handler", in_handler, 0);

        // mtvec low bits are forced to zero
        wr(12'h305, 32'h0000_0103);
        rd("mtvec_mask", 12'h305, 32'h100);

        // Enable MIE, then ecall at 0x40
        wr(12'h300, 32'h0000_0008);
        rd("mstatus_w", 12'h300, 32'h8);
        inst_valid = 1'b1; ecall = 1'b1; pc_cur = 32'h40; pc_next = 32'h44;
        #1;
        chk("ecall_redirect", redirect, 1);
        chk("ecall_rpc", redirect_pc, 32'h100);
        step(); clr();
        rd("ecall_mepc", 12'h341, 32'h40);
        rd("ecall_mcause", 12'h342, 32'd11);
        rd("ecall_mstatus", 12'h300, 32'h80);
        chk("ecall_in_handler", in_handler, 1);

        // mret back to 0x40
        inst_valid = 1'b1; mret = 1'b1;
        #1;
        chk("mret_redirect", redirect, 1);
        chk("mret_rpc", redirect_pc, 32'h40);
        step(); clr();
        rd("mret_mstatus", 12'h300, 32'h88);
        chk("mret_in_handler", in_handler, 0);

        // External interrupt latency: raised before edge k, acked after edge k+1
        wr(12'h304, 32'h0000_0800);
        rd("mie_w", 12'h304, 32'h800);
        inst_valid = 1'b1; pc_cur = 32'h20; pc_next = 32'h24; int_req = 1'b1;
        #1 chk("irq_ack_pre", int_ack, 0);
        step();
        chk("irq_ack_k", int_ack, 0);
        step();
        chk("irq_ack_k1", int_ack, 1);
        chk("irq_redirect", redirect, 1);
        chk("irq_rpc", redirect_pc, 32'h100);
        int_req = 1'b0;
        step();
        chk("irq_ack_k2", int_ack, 0);
        chk("irq_in_handler", in_handler, 1);
        clr();
        rd("irq_mepc", 12'h341, 32'h24);
        rd("irq_mcause", 12'h342, 32'h8000_000B);
        rd("irq_mstatus", 12'h300, 32'h80);
        step(); step();
        inst_valid = 1'b1; mret = 1'b1;
        #1 chk("irq_mret_rpc", redirect_pc, 32'h24);
        step(); clr();
        rd("irq_mret_mstatus", 12'h300, 32'h88);

        // Exception beats a pending interrupt
        int_req = 1'b1;
        step(); step(); step();
        rd("mip_pending", 12'h344, 32'h800);
        inst_valid = 1'b1; ill_instr = 1'b1; pc_cur = 32'h30; pc_next = 32'h34;
        #1;
        chk("ill_int_ack", int_ack, 0);
        chk("ill_rpc", redirect_pc, 32'h100);
        step(); clr();
        rd("ill_mcause", 12'h342, 32'd2);
        rd("ill_mepc", 12'h341, 32'h30);
        rd("ill_mstatus", 12'h300, 32'h80);
        chk("ill_in_handler", in_handler, 1);
        inst_valid = 1'b1;
        #1 chk("pend_mie0_ack", int_ack, 0);
        step();

        // mret with interrupt pending: mret wins, interrupt taken next cycle
        mret = 1'b1;
        #1;
        chk("mret_pend_ack", int_ack, 0);
        chk("mret_pend_rpc", redirect_pc, 32'h30);
        step();
        mret = 1'b0; pc_cur = 32'h2C; pc_next = 32'h30;
        #1;
        chk("pend_taken_ack", int_ack, 1);
        chk("pend_taken_rpc", redirect_pc, 32'h100);
        int_req = 1'b0;
        step(); clr();
        rd("pend_mepc", 12'h341, 32'h30);
        rd("pend_mcause", 12'h342, 32'h8000_000B);
        chk("pend_in_handler", in_handler, 1);

        // Double fault inside the handler
        inst_valid = 1'b1; ill_instr = 1'b1; pc_cur = 32'h60;
        #1;
        chk("dfault_redirect", redirect, 0);
        chk("dfault_ack", int_ack, 0);
        step(); clr();
        chk("dfault_halt", halt, 1);
        chk("dfault_in_handler", in_handler, 0);
        rd("dfault_mepc", 12'h341, 32'h30);
        rd("dfault_mcause", 12'h342, 32'h8000_000B);
        inst_valid = 1'b1; csr_we = 1'b1; csr_addr = 12'h305; csr_wdata = 32'h200;
        step(); clr();
        rd("halt_mtvec", 12'h305, 32'h100);
        inst_valid = 1'b1; mret = 1'b1;
        #1 chk("halt_mret_redirect", redirect, 0);
        step(); clr();
        chk("halt_stays", halt, 1);

        // Asynchronous reset out of HALT
        #2 rst = 1'b1;
        #1;
        chk("arst_halt", halt, 0);
        chk("arst_in_handler", in_handler, 0);
        rd("arst_mcause", 12'h342, 32'h0);
        rd("arst_mepc", 12'h341, 32'h0);
        #1 rst = 1'b0;
        step();
        chk("arst_redirect", redirect, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
